serdes_rx_deser: RTL and testbench

SERDES_RX_DESER -- requirements
Module: serdes_rx_deser

---
 rtl/serdes_rx_deser.sv | 231 +++++++++++++++++++++++
 tb/tb_serdes_rx_deser.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_rx_deser.sv
// Serial receiver/deserializer: oversampled UART-style framing (start, 8 data
// bits LSB first, optional parity, stop) with a valid/ready byte output.
// The serial line is double-synchronized before any decision is made.
module serdes_rx_deser #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  input  logic       ser_en,
  input  logic       par_en,
  input  logic       data_ready,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       par_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  // Bit-period counter width; a single bit is kept as a floor for tiny values.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Terminal counts: half a bit into the start bit, one full bit thereafter.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Synchronizer
  logic          sync1_q;
  logic          sync2_q;
  logic          s_in;

  // Receive FSM state
  state_t        state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q,   shift_d;
  logic          par_en_q,  par_en_d;
  logic          par_bit_q, par_bit_d;

  // Output holding register and pulses
  logic [7:0]    data_out_q,   data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          par_err_q,    par_err_d;
  logic          frame_err_q,  frame_err_d;
  logic          overrun_q,    overrun_d;

  // Frame-level events produced by the FSM for the output stage
  logic          frame_done;
  logic          frame_bad;
  logic          frame_par_err;
  logic          xfer;
  logic          sample_half;
  logic          sample_full;

  assign s_in = sync2_q;

  // Two-flop synchronizer on the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= ser_in;
      sync2_q <= sync1_q;
    end
  end

  assign sample_half = (cnt_q == HALF_LAST);
  assign sample_full = (cnt_q == FULL_LAST);

  // FSM next-state: bit timing, shifting, and stop-bit outcome.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    frame_done = 1'b0;
    frame_bad  = 1'b0;

    if (state_q != IDLE && !ser_en) begin
      // Receiver disabled mid-frame: drop everything silently.
      state_d   = IDLE;
      cnt_d     = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          if (ser_en && !s_in) begin
            state_d   = START;
            par_en_d  = par_en;
            par_bit_d = 1'b0;
          end
        end

        START: begin
          if (sample_half) begin
            cnt_d   = '0;
            // A line that is back high at mid-start was only a glitch.
            state_d = s_in ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        DATA: begin
          if (sample_full) begin
            cnt_d   = '0;
            shift_d = {s_in, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              state_d   = par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        PARITY: begin
          if (sample_full) begin
            cnt_d     = '0;
            par_bit_d = s_in;
            state_d   = STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        STOP: begin
          if (sample_full) begin
            cnt_d      = '0;
            state_d    = IDLE;
            frame_done = s_in;
            frame_bad  = !s_in;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        default: begin
          state_d   = IDLE;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  // FSM and shift-path registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  assign xfer          = data_valid_q & data_ready;
  // Mismatch flag: data XOR parity bit should equal the configured sense.
  assign frame_par_err = par_en_q & ((^shift_q) ^ par_bit_q ^ PAR_ODD);

  // Output stage: hold a byte until accepted; a completed frame that finds
  // the holding register full and not draining is dropped as an overrun.
  always_comb begin
    data_out_d   = data_out_q;
    par_err_d    = par_err_q;
    data_valid_d = data_valid_q & ~xfer;
    overrun_d    = 1'b0;
    frame_err_d  = frame_bad;

    if (frame_done) begin
      if (!data_valid_q || xfer) begin
        data_out_d   = shift_q;
        par_err_d    = frame_par_err;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serdes_rx_deser.sv
// Directed + randomized bench for serdes_rx_deser. A negedge monitor records
// transfers and pulses; the main sequence compares them to a frame-level model.
module tb_serdes_rx_deser;

  localparam int CPB  = 4;
  localparam int PODD = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser_in;
  logic       ser_en;
  logic       par_en;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       par_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  serdes_rx_deser #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .ser_en    (ser_en),
    .par_en    (par_en),
    .data_ready(data_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .par_err   (par_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Monitor state
  int         xfer_cnt     = 0;
  int         fe_cycles    = 0;
  int         ov_cycles    = 0;
  int         valid_cycles = 0;
  int         stab_bad     = 0;
  logic [8:0] got_q[$];
  logic       prev_valid   = 1'b0;
  logic       prev_xfer    = 1'b0;
  logic [8:0] prev_word    = '0;

  // Mid-cycle monitor: a transfer is valid&ready as seen before the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid && data_ready) begin
        got_q.push_back({par_err, data_out});
        xfer_cnt <= xfer_cnt + 1;
      end
      if (frame_err)  fe_cycles    <= fe_cycles + 1;
      if (overrun)    ov_cycles    <= ov_cycles + 1;
      if (data_valid) valid_cycles <= valid_cycles + 1;
      if (prev_valid && !prev_xfer && data_valid && ({par_err, data_out} != prev_word))
        stab_bad <= stab_bad + 1;
      prev_valid <= data_valid;
      prev_xfer  <= data_valid && data_ready;
      prev_word  <= {par_err, data_out};
    end else begin
      prev_valid <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_in = b;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb, input logic stopb);
    par_en = pe;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pe) send_bit(pb);
    send_bit(stopb);
    ser_in = 1'b1;
  endtask

  // Reference: total count of ones in data+parity must have the configured
  // oddness; anything else is a parity error. No parity means no error.
  function automatic logic model_perr(input logic [7:0] d, input logic pe, input logic pb);
    int ones;
    if (!pe) return 1'b0;
    ones = $countones(d) + int'(pb);
    return (ones % 2) != PODD;
  endfunction

  task automatic wait_got(input string tag);
    int t = 0;
    while (got_q.size() == 0 && t < 40) begin
      tick();
      t++;
    end
    check({tag, "_arrived"}, 32'(got_q.size() != 0), 32'd1);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] d, input logic perr);
    logic [8:0] w;
    wait_got(tag);
    if (got_q.size() != 0) begin
      w = got_q.pop_front();
      check({tag, "_data"}, 32'(w[7:0]), 32'(d));
      check({tag, "_perr"}, 32'(w[8]), 32'(perr));
    end
  endtask

  initial begin
    int         v0, fe0, ov0, x0, t;
    logic [7:0] d;
    logic       pe, pb;

    rst = 1'b1; ser_in = 1'b1; ser_en = 1'b1; par_en = 1'b0; data_ready = 1'b1;
    repeat (3) tick();
    check("rst_data_out",   32'(data_out),   32'h00);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_par_err",    32'(par_err),    32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    check("rst_overrun",    32'(overrun),    32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Plain byte, no parity, downstream always ready.
    v0 = valid_cycles;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    expect_byte("a5", 8'hA5, 1'b0);
    repeat (4) tick();
    check("a5_valid_width", 32'(valid_cycles - v0), 32'd1);

    // Even parity, correct then wrong parity bit.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    expect_byte("3c_p0", 8'h3C, model_perr(8'h3C, 1'b1, 1'b0));
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    expect_byte("3c_p1", 8'h3C, model_perr(8'h3C, 1'b1, 1'b1));

    // Randomized frames with random parity mode and parity bit.
    for (int n = 0; n < 12; n++) begin
      d  = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      pb = 1'($urandom_range(0, 1));
      send_frame(d, pe, pb, 1'b1);
      expect_byte($sformatf("rnd%0d", n), d, model_perr(d, pe, pb));
      repeat ($urandom_range(0, 6)) tick();
    end

    // One-cycle low glitch.
    repeat (4) tick();
    fe0 = fe_cycles; v0 = valid_cycles;
    ser_in = 1'b0; tick(); ser_in = 1'b1;
    t = 0;
    while (!busy && t < 10) begin tick(); t++; end
    check("glitch_busy_seen", 32'(busy), 32'd1);
    t = 0;
    while (busy && t < 20) begin tick(); t++; end
    check("glitch_busy_short", 32'(t <= CPB), 32'd1);
    repeat (6) tick();
    check("glitch_no_fe",    32'(fe_cycles - fe0),    32'd0);
    check("glitch_no_valid", 32'(valid_cycles - v0),  32'd0);

    // Bad stop bit.
    fe0 = fe_cycles; v0 = valid_cycles;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    check("fe_pulse",    32'(fe_cycles - fe0),   32'd1);
    check("fe_no_valid", 32'(valid_cycles - v0), 32'd0);
    check("fe_no_byte",  32'(got_q.size()),      32'd0);

    // Disable mid-frame: silent abort.
    fe0 = fe_cycles; v0 = valid_cycles;
    par_en = 1'b0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    ser_en = 1'b0; tick(); tick();
    check("dis_busy", 32'(busy), 32'd0);
    ser_en = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    repeat (6) tick();
    check("dis_no_fe",    32'(fe_cycles - fe0),   32'd0);
    check("dis_no_valid", 32'(valid_cycles - v0), 32'd0);

    // Overrun: second byte dropped while the first is held.
    data_ready = 1'b0;
    x0 = xfer_cnt; ov0 = ov_cycles;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    repeat (6) tick();
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    repeat (8) tick();
    check("ovr_pulse", 32'(ov_cycles - ov0), 32'd1);
    check("ovr_hold",  32'(data_out),        32'h11);
    check("ovr_valid", 32'(data_valid),      32'd1);
    check("ovr_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    data_ready = 1'b1;
    repeat (4) tick();
    check("ovr_one_xfer", 32'(xfer_cnt - x0), 32'd1);
    expect_byte("ovr_byte", 8'h11, 1'b0);
    check("ovr_drained", 32'(data_valid), 32'd0);

    // Completion in the same cycle as a transfer: load, no overrun.
    data_ready = 1'b0;
    x0 = xfer_cnt; ov0 = ov_cycles;
    send_frame(8'h33, 1'b0, 1'b0, 1'b1);
    repeat (6) tick();
    check("same_held", 32'(data_valid), 32'd1);
    send_frame(8'h44, 1'b0, 1'b0, 1'b1);
    data_ready = 1'b1;
    repeat (6) tick();
    check("same_no_ovr", 32'(ov_cycles - ov0), 32'd0);
    check("same_xfers",  32'(xfer_cnt - x0),   32'd2);
    expect_byte("same_first",  8'h33, 1'b0);
    expect_byte("same_second", 8'h44, 1'b0);

    // Asynchronous reset during data bit 4, then a clean frame.
    fe0 = fe_cycles; ov0 = ov_cycles;
    d = 8'h0F;
    par_en = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    ser_in = d[4];
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy",  32'(busy),       32'd0);
    check("arst_valid", 32'(data_valid), 32'd0);
    check("arst_data",  32'(data_out),   32'h00);
    tick(); tick(); tick();
    ser_in = 1'b1;
    rst = 1'b0;
    repeat (4) tick();
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
    expect_byte("after_rst", 8'h7E, 1'b0);
    repeat (4) tick();
    check("after_rst_only_one", 32'(got_q.size()),    32'd0);
    check("after_rst_no_fe",    32'(fe_cycles - fe0), 32'd0);
    check("after_rst_no_ovr",   32'(ov_cycles - ov0), 32'd0);

    check("hold_stability", 32'(stab_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
